// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes structured instruction requests into the one-byte CPU instruction
//   format. The encoded bytes pass through a small FIFO and are then written
//   one after another into program memory, starting at address 0.
//
//   Ports
//     clock, reset     clock; asynchronous active-high reset
//     start, finish    control pulses: begin a program / drain and complete
//     in_valid/ready   request handshake
//     in_kind          0=LOAD 1=ALU 2=COPY 3=COND
//     in_imm           LOAD immediate (must be <= 63)
//     in_op            ALU opcode or COND condition code
//     in_src, in_dst   COPY registers
//     mem_we/addr/wdata  program memory write port (registered)
//     busy, done       RUN|DRAIN, and DONE
//     prog_len         bytes written in the current program
//     err, err_sticky  rejected-request pulse and its sticky flag
module instr_encoder #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [7:0]        in_imm,
    input  logic [2:0]        in_op,
    input  logic [2:0]        in_src,
    input  logic [2:0]        in_dst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   prog_len,
    output logic              err,
    output logic              err_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    // FIFO pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]    fifo_q [DEPTH];
    logic [PW:0]   fifo_wp, fifo_rp;
    logic          fifo_empty, fifo_full;
    logic [ADDR_W:0] acc_cnt;

    logic       accept, imm_ok, push, pop, reject, start_run;
    logic [7:0] enc_byte;

    assign fifo_empty = (fifo_wp == fifo_rp);
    assign fifo_full  = (fifo_wp[PW] != fifo_rp[PW]) &&
                        (fifo_wp[PW-1:0] == fifo_rp[PW-1:0]);

    assign in_ready  = (state == S_RUN) && !fifo_full && (acc_cnt < CAP);
    assign accept    = in_valid && in_ready;
    assign imm_ok    = (in_kind != 2'd0) || (in_imm[7:6] == 2'b00);
    assign push      = accept && imm_ok;
    assign reject    = accept && !imm_ok;
    assign pop       = !fifo_empty;
    assign start_run = start && ((state == S_IDLE) || (state == S_DONE));

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        enc_byte = 8'h00;
        case (in_kind)
            2'd0: enc_byte = {2'b00, in_imm[5:0]};
            2'd1: enc_byte = {2'b01, 3'b000, in_op};
            2'd2: enc_byte = {2'b10, in_src, in_dst};
            2'd3: enc_byte = {2'b11, 3'b000, in_op};
            default: enc_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (finish) state_nxt = S_DRAIN;
            // mem_we still high means the last byte is being written this cycle
            S_DRAIN:        if (fifo_empty && !mem_we) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) fifo_q[fifo_wp[PW-1:0]] <= enc_byte;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            acc_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            prog_len   <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_we <= pop;
            err    <= reject;
            if (push) fifo_wp <= fifo_wp + (PW+1)'(1);
            if (pop) begin
                fifo_rp   <= fifo_rp + (PW+1)'(1);
                mem_wdata <= fifo_q[fifo_rp[PW-1:0]];
                // prog_len doubles as the write pointer; capacity stops it
                // before it could wrap.
                mem_addr  <= prog_len[ADDR_W-1:0];
                prog_len  <= prog_len + (ADDR_W+1)'(1);
            end
            // start_run only happens in IDLE/DONE, where the FIFO is empty,
            // so it never collides with a pop.
            if (start_run) begin
                acc_cnt    <= '0;
                mem_addr   <= '0;
                prog_len   <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (push)   acc_cnt    <= acc_cnt + (ADDR_W+1)'(1);
                if (reject) err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int ADDR_W = 4;
    localparam int CAPN   = 16;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic clock = 1'b0, reset = 1'b1;
    logic start = 0, finish = 0, in_valid = 0, in_ready;
    logic [1:0] in_kind = 0;
    logic [7:0] in_imm = 0;
    logic [2:0] in_op = 0, in_src = 0, in_dst = 0;
    logic mem_we, busy, done, err, err_sticky;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [ADDR_W:0] prog_len;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_imm(in_imm), .in_op(in_op), .in_src(in_src), .in_dst(in_dst),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .prog_len(prog_len), .err(err),
        .err_sticky(err_sticky));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int due; int addr; int data; } exp_t;
    exp_t exp_q[$];
    int   err_q[$];
    int   n_cmp = 0, n_fail = 0;

    // behavioural model of the program being assembled
    int mdl_state = M_IDLE, mdl_cnt = 0;
    bit mdl_sticky = 0;

    function automatic void chk(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic int enc_ref(int kind, int imm, int op, int src, int dst);
        case (kind)
            0: return imm;
            1: return 64 + op;
            2: return 128 + 8 * src + dst;
            default: return 192 + op;
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we) begin
                if (exp_q.size() == 0) chk("write_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", int'(mem_addr), e.addr);
                    chk("write_data", int'(mem_wdata), e.data);
                    chk("write_cycle", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("write_missing", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (err) begin
                if (err_q.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_cycle", cyc, err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] < cyc) begin
                chk("err_missing", cyc, err_q[0]);
                void'(err_q.pop_front());
            end
        end
    end

    task automatic send(input int kind, input int imm, input int op, input int src,
                        input int dst, input int max_wait);
        bit acc = 0, exp_acc;
        exp_acc = (mdl_state == M_RUN) && (mdl_cnt < CAPN);
        in_kind = 2'(kind); in_imm = 8'(imm); in_op = 3'(op);
        in_src = 3'(src); in_dst = 3'(dst);
        in_valid = 1'b1;
        for (int w = 0; w < max_wait && !acc; w++) begin
            if (in_ready) begin
                acc = 1;
                if (kind == 0 && imm > 63) begin
                    err_q.push_back(cyc + 1);
                    mdl_sticky = 1;
                end else begin
                    exp_q.push_back('{due: cyc + 2, addr: mdl_cnt,
                                      data: enc_ref(kind, imm, op, src, dst)});
                    mdl_cnt++;
                end
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("accept", int'(acc), int'(exp_acc));
    endtask

    task automatic send_rand(input int max_wait);
        int k;
        k = $urandom_range(0, 3);
        send(k, (k == 0) ? $urandom_range(0, 80) : $urandom_range(0, 255),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), max_wait);
    endtask

    task automatic ctl(input bit s, input bit f);
        start = s; finish = f;
        if (s && (mdl_state == M_IDLE || mdl_state == M_DONE)) begin
            mdl_state = M_RUN; mdl_cnt = 0; mdl_sticky = 0;
        end else if (f && mdl_state == M_RUN) mdl_state = M_DRAIN;
        @(negedge clock);
        start = 0; finish = 0;
    endtask

    task automatic wait_done();
        for (int w = 0; w < 30 && !done; w++) @(negedge clock);
        chk("done", int'(done), 1);
        if (done) mdl_state = M_DONE;
        chk("busy_done", int'(busy), 0);
        chk("prog_len", int'(prog_len), mdl_cnt);
        chk("err_sticky", int'(err_sticky), int'(mdl_sticky));
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_prog_len"}, int'(prog_len), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_sticky"}, int'(err_sticky), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        reset = 0;
        @(negedge clock);

        // encoding of each kind
        ctl(1, 0);
        chk("busy_run", int'(busy), 1);
        send(0, 8'h2A, 0, 0, 0, 4);
        send(1, 0, 5, 0, 0, 4);
        send(2, 0, 0, 3, 6, 4);
        send(3, 0, 2, 0, 0, 4);
        ctl(0, 1);
        wait_done();

        // back-to-back throughput; start+finish together in DONE: start wins
        ctl(1, 1);
        chk("done_drop", int'(done), 0);
        chk("busy_restart", int'(busy), 1);
        for (int i = 0; i < 6; i++) send(1, 0, i, 0, 0, 4);
        ctl(0, 1);
        wait_done();

        // invalid immediate between two valid loads
        ctl(1, 0);
        send(0, 1, 0, 0, 0, 4);
        send(0, 64, 0, 0, 0, 4);
        send(0, 2, 0, 0, 0, 4);
        repeat (3) @(negedge clock);
        chk("sticky_after_err", int'(err_sticky), 1);
        ctl(0, 1);
        wait_done();

        // capacity, with an ignored start in the middle of RUN
        ctl(1, 0);
        chk("sticky_cleared", int'(err_sticky), 0);
        for (int i = 0; i < 20; i++) begin
            send(2, 0, 0, i % 8, (i * 3) % 8, 2);
            if (i == 7) ctl(1, 0);
        end
        chk("in_ready_full", int'(in_ready), 0);
        chk("busy_full", int'(busy), 1);
        ctl(0, 1);
        wait_done();

        // reset mid-program after three writes
        ctl(1, 0);
        send(0, 99, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) send(1, 0, i, 0, 0, 4);
        #2;
        reset = 1;
        exp_q.delete(); err_q.delete();
        mdl_state = M_IDLE; mdl_cnt = 0; mdl_sticky = 0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        ctl(1, 0);
        send(3, 0, 7, 0, 0, 4);
        send(0, 63, 0, 0, 0, 4);
        ctl(0, 1);
        wait_done();

        // randomized programs; start+finish together in RUN: finish wins
        for (int p = 0; p < 4; p++) begin
            int n;
            ctl(1, 0);
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                send_rand(4);
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            ctl(1, (p % 2 == 0) ? 1'b1 : 1'b1);
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
